// File: rtl/serial_eq_ctrl_pkg.sv
// rtl/serial_eq_ctrl_pkg.sv - shared states and width helpers for the serial equality controller
package serial_eq_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE    = 2'd0;
  localparam state_t S_COMPARE = 2'd1;
  localparam state_t S_DONE    = 2'd2;

  // Pair-index width; a single pair still needs a one-bit index port.
  function automatic int calc_pw(input int width);
    int n;
    n = width / 2;
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit width_ok(input int width);
    return (width >= 2) && ((width % 2) == 0);
  endfunction

endpackage

// File: rtl/serial_eq_ctrl_slice.sv
// rtl/serial_eq_ctrl_slice.sv - two-bit equality slice reused by the serial comparator
module two_bit_equality (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       c
);

  assign c = (a == b);

endmodule

// File: rtl/serial_eq_ctrl.sv
// rtl/serial_eq_ctrl.sv - serial WIDTH-bit equality compare, one bit-pair per clock, early exit
module serial_eq_ctrl
  import serial_eq_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PW    = calc_pw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic [PW-1:0]    mismatch_pos
);

  localparam logic [PW-1:0] K_LAST = PW'(WIDTH / 2 - 1);

  generate
    if (!width_ok(WIDTH)) begin : g_bad_width
      $error("serial_eq_ctrl: WIDTH must be even and at least 2");
    end
  endgenerate

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [PW-1:0]    k;
  logic             pair_eq;
  logic             last_pair;

  two_bit_equality u_slice (
    .a (sa[1:0]),
    .b (sb[1:0]),
    .c (pair_eq)
  );

  assign last_pair = (k == K_LAST);
  assign ready     = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_COMPARE;
      end
      S_COMPARE: begin
        if (!pair_eq || last_pair) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Result registers only move on the edge entering DONE so they hold across the next compare.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      sa           <= '0;
      sb           <= '0;
      k            <= '0;
      equal        <= 1'b0;
      mismatch_pos <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            sa <= a;
            sb <= b;
            k  <= '0;
          end
        end
        S_COMPARE: begin
          if (!pair_eq) begin
            equal        <= 1'b0;
            mismatch_pos <= k;
          end else if (last_pair) begin
            equal        <= 1'b1;
            mismatch_pos <= '0;
          end else begin
            sa <= sa >> 2;
            sb <= sb >> 2;
            k  <= k + PW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
